// File: rtl/i2c_slave_if_if.sv
// I2C bus-side signals for one slave endpoint. The slave never drives SCL;
// SDA is open-drain, with the wired-AND formed outside the slave.
interface i2c_slave_if_if;
    logic scl_i;
    logic sda_i;
    logic sda_o;

    modport slave  (input  scl_i, input  sda_i, output sda_o);
    modport master (output scl_i, output sda_i, input  sda_o);
endinterface

// File: rtl/i2c_slave_if.sv
// I2C target endpoint: 7-bit address, write bytes to an rx strobe,
// read bytes from a preloadable transmit FIFO. Oversampled, never stretches SCL.
module i2c_slave_if #(
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [7:0]  IDLE_READ_BYTE = 8'hFF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    i2c_slave_if_if.slave  bus,
    input  logic [6:0]     slave_addr,
    input  logic           tx_push,
    input  logic [7:0]     tx_data,
    output logic           tx_full,
    output logic           tx_empty,
    output logic           rx_valid,
    output logic [7:0]     rx_data,
    output logic [7:0]     most_recent_xfer,
    output logic           busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_WR_DATA   = 3'd2;
    localparam logic [2:0] ST_RD_DATA   = 3'd3;
    localparam logic [2:0] ST_RD_ACK    = 3'd4;
    localparam logic [2:0] ST_IGNORE    = 3'd5;
    localparam logic [2:0] ST_WAIT_STOP = 3'd6;

    localparam int unsigned AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    logic [2:0]  r_state;
    logic [3:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_rw;
    logic        r_match;
    logic        r_mack;
    logic [7:0]  r_tx_byte;
    logic [6:0]  r_tx_shift;
    logic        r_sda_o;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic [7:0]  r_mrx;
    logic        r_busy;

    logic [7:0]  r_mem [TX_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic [7:0]  w_head;
    logic        w_load;
    logic        w_pop;
    logic        w_push_ok;

    // Synchronizers reset high so an idle bus is not mistaken for a START.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        w_scl        = r_scl_sync[SYNC_STAGES-1];
        w_sda        = r_sda_sync[SYNC_STAGES-1];
        w_scl_rise   = w_scl & ~r_scl_d;
        w_scl_fall   = ~w_scl & r_scl_d;
        w_start      = w_scl & r_scl_d & r_sda_d & ~w_sda;
        w_stop       = w_scl & r_scl_d & ~r_sda_d & w_sda;
        w_shift_next = {r_shift, w_sda};
    end

    always_comb begin
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_head    = w_empty ? IDLE_READ_BYTE : r_mem[r_rd_ptr[AW-1:0]];
        // A byte is loaded on the SCL fall that ends an ACK leading into a read.
        w_load    = ~w_start & ~w_stop & w_scl_fall && (r_bitcnt == 4'd9) &&
                    (((r_state == ST_ADDR) && r_match && r_rw) ||
                     ((r_state == ST_RD_ACK) && r_mack));
        w_pop     = w_load & ~w_empty;
        w_push_ok = tx_push & (~w_full | w_pop);
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_rw       <= 1'b0;
            r_match    <= 1'b0;
            r_mack     <= 1'b0;
            r_tx_byte  <= '0;
            r_tx_shift <= '0;
            r_sda_o    <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_mrx      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ST_ADDR;
                r_bitcnt <= '0;
                r_sda_o  <= 1'b1;
                r_busy   <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                r_sda_o  <= 1'b1;
                r_busy   <= 1'b0;
            end else if (w_load) begin
                r_state    <= ST_RD_DATA;
                r_bitcnt   <= '0;
                r_tx_byte  <= w_head;
                r_tx_shift <= w_head[6:0];
                r_sda_o    <= w_head[7];
            end else begin
                case (r_state)
                    ST_ADDR, ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            if (r_bitcnt < 4'd8) begin
                                r_shift  <= w_shift_next[6:0];
                                r_bitcnt <= r_bitcnt + 4'd1;
                                if (r_bitcnt == 4'd7) begin
                                    if (r_state == ST_ADDR) begin
                                        r_rw    <= w_sda;
                                        r_match <= (w_shift_next[7:1] == slave_addr);
                                    end else begin
                                        r_rx_valid <= 1'b1;
                                        r_rx_data  <= w_shift_next;
                                        r_mrx      <= w_shift_next;
                                    end
                                end
                            end else if (r_bitcnt == 4'd8) begin
                                r_bitcnt <= 4'd9;
                            end
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                if ((r_state == ST_WR_DATA) || r_match) begin
                                    r_sda_o <= 1'b0;
                                    if (r_state == ST_ADDR) begin
                                        r_busy <= 1'b1;
                                    end
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else if (r_bitcnt == 4'd9) begin
                                r_sda_o  <= 1'b1;
                                r_bitcnt <= '0;
                                r_state  <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_scl_rise && (r_bitcnt < 4'd8)) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_o <= 1'b1;
                                r_mrx   <= r_tx_byte;
                                r_state <= ST_RD_ACK;
                            end else if (r_bitcnt != 4'd0) begin
                                r_sda_o    <= r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b1};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= 4'd9;
                            r_mack   <= ~w_sda;
                            if (w_sda) begin
                                r_state <= ST_WAIT_STOP;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE, ST_WAIT_STOP: begin
                        r_sda_o <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_sda_o <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.sda_o        = r_sda_o;
    assign tx_full          = w_full;
    assign tx_empty         = w_empty;
    assign rx_valid         = r_rx_valid;
    assign rx_data          = r_rx_data;
    assign most_recent_xfer = r_mrx;
    assign busy             = r_busy;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench: bit-banged I2C master driving two slaves (0x12, 0x13) on one bus.
module tb_i2c_slave_if;

    localparam int Q = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       bus_sda;

    i2c_slave_if_if bus0();
    i2c_slave_if_if bus1();

    assign bus_sda    = m_sda & bus0.sda_o & bus1.sda_o;
    assign bus0.scl_i = m_scl;
    assign bus0.sda_i = bus_sda;
    assign bus1.scl_i = m_scl;
    assign bus1.sda_i = bus_sda;

    logic       tx_push0;
    logic [7:0] tx_data0;
    logic       tx_full0, tx_empty0, rx_valid0, busy0;
    logic [7:0] rx_data0, mrx0;
    logic       tx_full1, tx_empty1, rx_valid1, busy1;
    logic [7:0] rx_data1, mrx1;

    i2c_slave_if #(.TX_DEPTH(16), .SYNC_STAGES(2), .IDLE_READ_BYTE(8'hFF)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0), .slave_addr(7'h12),
        .tx_push(tx_push0), .tx_data(tx_data0), .tx_full(tx_full0), .tx_empty(tx_empty0),
        .rx_valid(rx_valid0), .rx_data(rx_data0), .most_recent_xfer(mrx0), .busy(busy0)
    );

    i2c_slave_if #(.TX_DEPTH(16), .SYNC_STAGES(2), .IDLE_READ_BYTE(8'hFF)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus1), .slave_addr(7'h13),
        .tx_push(1'b0), .tx_data(8'h00), .tx_full(tx_full1), .tx_empty(tx_empty1),
        .rx_valid(rx_valid1), .rx_data(rx_data1), .most_recent_xfer(mrx1), .busy(busy1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    int         s1_pulled = 0;
    int         s1_rx     = 0;
    int         idle_cnt  = 0;
    logic [2:0] prev_state0 = 3'd0;

    always @(negedge clk) begin
        if (rx_valid0 === 1'b1) rx_q.push_back(rx_data0);
        if (bus1.sda_o === 1'b0) s1_pulled++;
        if (rx_valid1 === 1'b1) s1_rx++;
        if ((dut0.r_state == 3'd0) && (prev_state0 != 3'd0)) idle_cnt++;
        prev_state0 = dut0.r_state;
    end

    task automatic qw();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b0; qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        m_scl = 1'b0;
        m_sda = 1'b0; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b1; qw();
        qw();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; qw();
            m_scl = 1'b1; qw(); qw();
            m_scl = 1'b0; qw();
        end
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        ack = (bus_sda == 1'b0);
        qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; qw();
            m_scl = 1'b1; qw();
            b[i] = bus_sda;
            qw();
            m_scl = 1'b0; qw();
        end
        m_sda = nack; qw();
        m_scl = 1'b1; qw(); qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic push0(input logic [7:0] d);
        tx_push0 = 1'b1;
        tx_data0 = d;
        @(posedge clk); #1;
        tx_push0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; tx_push0 = 1'b0; tx_data0 = 8'h00;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus0.sda_o !== 1'b1) $display("FAIL reset_sda_o: got %b expected 1", bus0.sda_o); else n_pass++;
        n_checks++; if (rx_valid0 !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid0); else n_pass++;
        n_checks++; if (rx_data0 !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data0); else n_pass++;
        n_checks++; if (mrx0 !== 8'h00) $display("FAIL reset_mrx: got %h expected 00", mrx0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else n_pass++;
        n_checks++; if (tx_empty0 !== 1'b1) $display("FAIL reset_tx_empty: got %b expected 1", tx_empty0); else n_pass++;
        n_checks++; if (tx_full0 !== 1'b0) $display("FAIL reset_tx_full: got %b expected 0", tx_full0); else n_pass++;
    endtask

    task automatic test_write_burst();
        logic ack;
        rx_q.delete();
        i2c_start();
        write_byte(8'h24, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b expected 1", ack); else n_pass++;
        n_checks++; if (busy0 !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            write_byte(8'(i), ack);
            n_checks++; if (ack !== 1'b1) $display("FAIL wr_data_ack[%0d]: got %b expected 1", i, ack); else n_pass++;
        end
        i2c_stop();
        n_checks++; if (rx_q.size() != 8) $display("FAIL wr_rx_count: got %0d expected 8", rx_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'(i)) $display("FAIL wr_rx_data[%0d]: got %h expected %h", i, rx_q[i], 8'(i)); else n_pass++;
        end
        n_checks++; if (mrx0 !== 8'h07) $display("FAIL wr_mrx: got %h expected 07", mrx0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL wr_busy_after_stop: got %b expected 0", busy0); else n_pass++;
    endtask

    task automatic test_read_burst();
        logic ack;
        logic [7:0] b;
        for (int i = 8; i < 16; i++) push0(8'(i));
        i2c_start();
        write_byte(8'h25, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL rd_addr_ack: got %b expected 1", ack); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            read_byte(i == 7, b);
            n_checks++; if (b !== 8'(8 + i)) $display("FAIL rd_data[%0d]: got %h expected %h", i, b, 8'(8 + i)); else n_pass++;
        end
        n_checks++; if (busy0 !== 1'b0) $display("FAIL rd_busy_after_nack: got %b expected 0", busy0); else n_pass++;
        i2c_stop();
        n_checks++; if (tx_empty0 !== 1'b1) $display("FAIL rd_tx_empty: got %b expected 1", tx_empty0); else n_pass++;
        n_checks++; if (mrx0 !== 8'h0F) $display("FAIL rd_mrx: got %h expected 0F", mrx0); else n_pass++;
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) push0(8'hA0 + 8'(i));
        idle_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            i2c_start();
            write_byte(8'h24, ack);
            write_byte(8'(i), ack);
            n_checks++; if (ack !== 1'b1) $display("FAIL rs_wr_ack[%0d]: got %b expected 1", i, ack); else n_pass++;
            n_checks++; if (rx_data0 !== 8'(i)) $display("FAIL rs_rx_data[%0d]: got %h expected %h", i, rx_data0, 8'(i)); else n_pass++;
            i2c_start();
            write_byte(8'h25, ack);
            read_byte(1'b1, b);
            n_checks++; if (b !== 8'hA0 + 8'(i)) $display("FAIL rs_rd_data[%0d]: got %h expected %h", i, b, 8'hA0 + 8'(i)); else n_pass++;
        end
        n_checks++; if (idle_cnt != 0) $display("FAIL rs_no_spurious_stop: got %0d idle entries expected 0", idle_cnt); else n_pass++;
        i2c_stop();
        n_checks++; if (idle_cnt != 1) $display("FAIL rs_final_stop: got %0d idle entries expected 1", idle_cnt); else n_pass++;
    endtask

    task automatic test_two_slaves();
        logic ack;
        rx_q.delete();
        s1_pulled = 0;
        s1_rx = 0;
        i2c_start();
        write_byte(8'h24, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL ts_addr_ack: got %b expected 1", ack); else n_pass++;
        write_byte(8'h5A, ack);
        n_checks++; if (dut1.r_state !== 3'd5) $display("FAIL ts_s1_ignore: got %0d expected 5", dut1.r_state); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL ts_s1_busy: got %b expected 0", busy1); else n_pass++;
        i2c_stop();
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) $display("FAIL ts_s0_rx: got %0d bytes expected 1 byte 5a", rx_q.size()); else n_pass++;
        n_checks++; if (s1_pulled != 0) $display("FAIL ts_s1_sda: got %0d low cycles expected 0", s1_pulled); else n_pass++;
        n_checks++; if (s1_rx != 0) $display("FAIL ts_s1_rx: got %0d pulses expected 0", s1_rx); else n_pass++;
    endtask

    task automatic test_under_overflow();
        logic ack;
        logic [7:0] b;
        i2c_start();
        write_byte(8'h25, ack);
        read_byte(1'b1, b);
        i2c_stop();
        n_checks++; if (b !== 8'hFF) $display("FAIL uf_data: got %h expected ff", b); else n_pass++;
        n_checks++; if (mrx0 !== 8'hFF) $display("FAIL uf_mrx: got %h expected ff", mrx0); else n_pass++;
        for (int i = 0; i < 16; i++) push0(8'h30 + 8'(i));
        n_checks++; if (tx_full0 !== 1'b1) $display("FAIL of_full16: got %b expected 1", tx_full0); else n_pass++;
        push0(8'h40);
        n_checks++; if (tx_full0 !== 1'b1) $display("FAIL of_full17: got %b expected 1", tx_full0); else n_pass++;
        i2c_start();
        write_byte(8'h25, ack);
        for (int i = 0; i < 16; i++) begin
            read_byte(i == 15, b);
            n_checks++; if (b !== 8'h30 + 8'(i)) $display("FAIL of_data[%0d]: got %h expected %h", i, b, 8'h30 + 8'(i)); else n_pass++;
        end
        i2c_stop();
        n_checks++; if (tx_empty0 !== 1'b1) $display("FAIL of_empty: got %b expected 1", tx_empty0); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        push0(8'h00);
        push0(8'h55);
        i2c_start();
        write_byte(8'h25, ack);
        n_checks++; if (bus0.sda_o !== 1'b0) $display("FAIL rm_driving_zero: got %b expected 0", bus0.sda_o); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.sda_o !== 1'b1) $display("FAIL rm_sda_async: got %b expected 1", bus0.sda_o); else n_pass++;
        n_checks++; if (dut0.r_state !== 3'd0) $display("FAIL rm_state: got %0d expected 0", dut0.r_state); else n_pass++;
        n_checks++; if (tx_empty0 !== 1'b1) $display("FAIL rm_tx_empty: got %b expected 1", tx_empty0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy0); else n_pass++;
        m_scl = 1'b1;
        m_sda = 1'b1;
        qw();
        rst_n = 1'b1;
        qw();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_repeated_start();
        test_two_slaves();
        test_under_overflow();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_if.md
Name: i2c_slave_if

Overview:
- Synthesizable I2C slave (target) endpoint, 7-bit addressing, 8-bit data, standard-mode/fast-mode bus rates up to 400 kHz.
- Sits on one I2C bus segment, opposite an I2C master controller.
- ACKs its configured address and captures write bytes to a receive strobe interface.
- Answers read requests from a preloadable transmit FIFO.
- Exposes the last transferred byte for scoreboard/debug.

Parameters:
- TX_DEPTH, 16, transmit FIFO entries (power of two).
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i.
- IDLE_READ_BYTE, 8'hFF, byte sent when a read occurs with an empty FIFO.

Ports:
- clk_i  in  1  system clock; must be at least 20x the SCL rate.
- rst_i  in  1  asynchronous, active-low reset.
- scl_i  in  1  I2C clock, bus level.
- sda_i  in  1  I2C data, bus level.
- sda_o  out  1  open-drain control: 0 = pull SDA low, 1 = release. The top level forms the wired-AND.
- slave_addr  in  7  own address; sampled at each address phase.
- tx_push  in  1  write tx_data into the transmit FIFO.
- tx_data  in  8  transmit FIFO write data.
- tx_full  out  1  FIFO full; a push while full is dropped.
- tx_empty  out  1  FIFO empty.
- rx_valid  out  1  one-clk pulse when a master-written data byte completes.
- rx_data  out  8  received byte, held until the next rx_valid.
- most_recent_xfer  out  8  last completed data byte, either direction.
- busy  out  1  high from address match until STOP, repeated START, or NACK release.

Behaviour:
- Reset (rst_i low, asynchronous):
  - sda_o=1, rx_valid=0, rx_data=0, most_recent_xfer=0, busy=0.
  - FIFO emptied: tx_empty=1, tx_full=0.
  - State IDLE.
- Input conditioning: scl_i and sda_i pass through SYNC_STAGES flops. Edges are detected on the synchronized copies; all logic works on these.
- START: sda falls while scl high. Recognised in every state, including mid-byte, so repeated START is handled. Action: bit counter cleared, release SDA, enter ADDR.
- STOP: sda rises while scl high. Action: enter IDLE, release SDA, busy=0. STOP in the middle of a byte discards the partial byte.
- Bit sampling: on scl rising edge, MSB first.
- Slave-driven SDA: changes only on the synchronized scl falling edge, and is held through the following high phase.
- ADDR:
  - Shift 8 bits (7 address + R/W).
  - On the 8th bit, compare against slave_addr.
  - Match: drive ACK (sda_o=0) for the 9th clock, set busy, then enter WR_DATA (R/W=0) or RD_DATA (R/W=1).
  - Mismatch: leave SDA released (NACK) and enter IGNORE until the next START/STOP.
- WR_DATA:
  - Shift 8 bits, then drive ACK for the 9th clock.
  - Pulse rx_valid with rx_data=byte on the clk after the 8th rising edge, and update most_recent_xfer.
  - Always ACK; there is no backpressure.
  - Loop to WR_DATA.
- RD_DATA:
  - On entry, pop the FIFO head. If the FIFO is empty, use IDLE_READ_BYTE.
  - Drive bits MSB first; a 0 bit sets sda_o=0, a 1 bit releases.
  - After the 8th bit's falling edge, release SDA and enter RD_ACK.
  - Update most_recent_xfer when the byte completes.
- RD_ACK: sample SDA on the 9th rising edge.
  - Low (ACK): load the next byte and return to RD_DATA.
  - High (NACK): release SDA and enter WAIT_STOP (busy=0).
- IGNORE/WAIT_STOP: SDA released; only START/STOP are acted on.
- FIFO:
  - Push and pop in the same clk are both honoured.
  - Push when full is dropped; pop when empty does not move the pointers.
  - Pointers wrap modulo TX_DEPTH.
- Clock stretching: never stretched; scl is input-only.
- Reset mid-transaction releases SDA immediately, asynchronously.

Test Plan:
- Write burst: slave_addr=7'h12; master sends START, 8'h24 (0x12<<1|0), then data 0x00..0x07, then STOP.
  - ACK on all 9 bytes.
  - rx_valid pulses 8 times with data 0..7.
  - most_recent_xfer=0x07 and busy=0 after STOP.
- Read burst: preload 0x08..0x0F; START, 8'h25.
  - Master ACKs 7 bytes and NACKs the 8th, then STOP.
  - Master receives 0x08..0x0F; tx_empty=1; most_recent_xfer=0x0F.
- Alternating repeated START, 8 iterations: START + 8'h24 + one write byte i, then repeated START + 8'h25 + one read byte with NACK; single STOP at the end.
  - Writes i are seen on rx_data.
  - Reads return successive FIFO entries.
  - No spurious STOP is detected.
- Two slaves sharing one bus, addresses 0x12 and 0x13: master addresses 0x12.
  - Only that slave ACKs and reports rx_valid.
  - The other stays in IGNORE with sda_o=1 throughout.
- Underflow/overflow:
  - Read with an empty FIFO returns 0xFF.
  - Push 17 bytes into TX_DEPTH=16: the 17th is dropped and tx_full=1.
- Reset mid-read while the slave drives a 0 bit: sda_o goes to 1 without a clk edge; state IDLE; FIFO empty.
